// File: rtl/mac.sv
// Signed multiply-accumulate core. Each edge adds the full-precision product
// a*b into the accumulator; a synchronous active-low reset loads a signed bias.
module mac #(
  parameter int VAR_SIZE = 8,
  parameter int ACC_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VAR_SIZE-1:0] a,
  input  logic [VAR_SIZE-1:0] b,
  input  logic [ACC_SIZE-1:0] bias,
  output logic [ACC_SIZE-1:0] acc
);

  logic signed [2*VAR_SIZE-1:0] a_ext;
  logic signed [2*VAR_SIZE-1:0] b_ext;
  logic signed [2*VAR_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]   prod_ext;
  logic        [ACC_SIZE-1:0]   acc_d;
  logic        [ACC_SIZE-1:0]   acc_q;

  // Widen both operands first so the multiply is exact at 2*VAR_SIZE bits.
  assign a_ext    = {{VAR_SIZE{a[VAR_SIZE-1]}}, a};
  assign b_ext    = {{VAR_SIZE{b[VAR_SIZE-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_SIZE'(prod);

  // Modulo 2^ACC_SIZE add: overflow wraps, no saturation.
  always_comb begin
    acc_d = acc_q + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= bias;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: tb/tb_mac.sv
// Randomized and directed bench for mac: inputs driven and acc checked on the
// falling edge, expected values from an integer reference model.
module tb_mac;

  localparam int VS = 8;
  localparam int AS = 32;

  logic          clk;
  logic          rst_n;
  logic [VS-1:0] a;
  logic [VS-1:0] b;
  logic [AS-1:0] bias;
  logic [AS-1:0] acc;

  int checks;
  int failures;

  logic [AS-1:0] exp_q[$];
  int            model_acc;

  mac #(.VAR_SIZE(VS), .ACC_SIZE(AS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .bias (bias),
    .acc  (acc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [AS-1:0] got,
                           input logic [AS-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: acc=%0d (0x%08h) expected=%0d (0x%08h)",
               tag, $signed(got), got, $signed(want), want);
    end
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge's
  // result, then compare at the following falling edge.
  task automatic step(input string tag, input logic rst_v, input int bias_v,
                      input int a_v, input int b_v);
    byte sa;
    byte sb;
    rst_n = rst_v;
    bias  = AS'(bias_v);
    a     = VS'(a_v);
    b     = VS'(b_v);
    sa = byte'(a_v);
    sb = byte'(b_v);
    if (!rst_v) model_acc = bias_v;
    else        model_acc = model_acc + int'(sa) * int'(sb);
    exp_q.push_back(AS'(model_acc));
    @(negedge clk);
    check_val(tag, acc, exp_q.pop_front());
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_acc = 0;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    bias  = '0;
    @(negedge clk);

    // reset load, operands ignored during reset
    step("reset_m7", 1'b0, -7, 0, 0);
    step("reset_ignore_ops", 1'b0, 9, 5, 5);

    // accumulate
    step("acc_bias3", 1'b0, 3, 0, 0);
    step("acc_1", 1'b1, 0, 4, -6);
    step("acc_2", 1'b1, 0, 4, -6);
    step("acc_hold_a0", 1'b1, 0, 0, 77);
    step("acc_hold_b0", 1'b1, 123, -99, 0);

    // sign extremes
    step("ext_reset", 1'b0, 0, 0, 0);
    step("ext_m128_m128", 1'b1, 0, -128, -128);
    step("ext_m128_127", 1'b1, 0, -128, 127);

    // wrap-around
    step("wrap_reset", 1'b0, 2147483647, 0, 0);
    step("wrap_add1", 1'b1, 0, 1, 1);

    // mid-run reset
    step("mid_reset0", 1'b0, 5, 0, 0);
    for (int i = 0; i < 6; i++)
      step("mid_acc", 1'b1, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    step("mid_reset_m2", 1'b0, -2, 100, 100);
    step("mid_resume", 1'b1, 0, 3, 7);

    // random regression
    for (int i = 0; i < 100; i++) begin
      step("rand", ($urandom_range(0, 7) != 0),
           int'($urandom_range(0, 18)) - 9,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac.md
# mac

Signed multiply-accumulate unit: each clock it multiplies two signed VAR_SIZE-bit operands and adds the full-precision product into a signed ACC_SIZE-bit accumulator register. A synchronous reset preloads the accumulator with a signed bias value. It is the processing-element arithmetic core used in the matrix-processing array, where each cell accumulates a dot product seeded with a bias term.

## Interface
Parameters:
- VAR_SIZE, default 8: width of the signed operands a and b.
- ACC_SIZE, default 32: width of the signed bias and of the accumulator. The requirement ACC_SIZE >= 2*VAR_SIZE applies.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  reset: rst_n, synchronous, active-low; clock clk.
- a  input  VAR_SIZE  signed multiplicand (two's complement).
- b  input  VAR_SIZE  signed multiplier (two's complement).
- bias  input  ACC_SIZE  signed value loaded into the accumulator on reset.
- acc  output  ACC_SIZE  signed accumulator register, driven directly from the flop.

## Operation
- On each rising edge of clk:
  - If rst_n == 0, then acc <= bias. a and b are ignored on this edge.
  - Otherwise, acc <= acc + (a * b).
- Product:
  - Signed full-precision 2*VAR_SIZE-bit product of a and b.
  - Sign-extended to ACC_SIZE before the add.
  - No truncation of the product.
- Add is two's-complement modulo 2^ACC_SIZE.
  - Overflow wraps silently.
  - No saturation and no overflow flag.
- Reset is a load, not a clear. It can be asserted on any cycle, including mid-accumulation, and takes effect on that edge, discarding the prior sum.
- bias is only sampled on edges where rst_n == 0. Between resets it has no effect.
- No enable input. Accumulation happens on every non-reset edge. Driving a = 0 or b = 0 holds the value.
- Operands are purely combinational into the adder. No input registers.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on acc after edge N and stay stable until edge N+1.
- acc is undefined (X) until the first edge with rst_n == 0. Environments must reset before use.
- No handshake. The block accepts new a, b, bias and rst_n every cycle.
- Setup requirement: inputs must be stable before the rising edge. The bench drives them at the falling edge and checks acc at the falling edge.
- Critical path is multiplier → adder → acc flop. It must close in one cycle at the target clock. Pipelining is not permitted because it would change the latency.

## Test plan
- Reset load: rst_n = 0, bias = -7 for one edge, then acc == -7. With rst_n = 0, bias = 9, a = 5, b = 5, acc == 9 (operands ignored).
- Accumulate: after reset with bias = 3, apply rst_n = 1 with a = 4, b = -6 for 2 edges. Then acc == -21 and acc == -45.
- Sign extremes: reset with bias = 0, then a = -128, b = -128, giving acc == 16384. Next, a = -128, b = 127, giving acc == 128.
- Wrap-around: reset with bias = 2147483647, then a = 1, b = 1. acc == -2147483648, with no saturation.
- Mid-run reset: accumulate several random products, then assert rst_n = 0 with bias = -2. acc == -2 on that edge and the prior sum is discarded. Accumulation resumes from -2.
- Random regression, 100 cycles:
  - Stimulus each falling edge: random a and b, bias in [-9, 9], random rst_n.
  - Reference model at the rising edge: if !rst_n then bias, else prior + a*b (32-bit signed).
  - Check: acc must match exactly (===) at every falling edge; score must be 100/100.
